// File: rtl/pipeline_reg_de.sv
// rtl/pipeline_reg_de.sv - decode-to-execute pipeline register with writeback bypass and load-use bubble
// Optional bubble counter enabled by macro PIPE_DE_BUBBLE_CNT_EN.
module pipeline_reg_de #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int CTRL_WIDTH    = 16
) (
    input  logic                     iClk,
    input  logic                     iRstN,
    input  logic                     iValidD,
    input  logic [DATA_WIDTH-1:0]    iPCD,
    input  logic [ADDRESS_WIDTH-1:0] iRs1AddrD,
    input  logic [ADDRESS_WIDTH-1:0] iRs2AddrD,
    input  logic [ADDRESS_WIDTH-1:0] iRdAddrD,
    input  logic [DATA_WIDTH-1:0]    iRegData1D,
    input  logic [DATA_WIDTH-1:0]    iRegData2D,
    input  logic [DATA_WIDTH-1:0]    iImmD,
    input  logic [CTRL_WIDTH-1:0]    iCtrlD,
    input  logic                     iWbWriteEn,
    input  logic [ADDRESS_WIDTH-1:0] iWbAddr,
    input  logic [DATA_WIDTH-1:0]    iWbData,
    input  logic                     iStallE,
    input  logic                     iFlush,
    output logic                     oValidE,
    output logic [DATA_WIDTH-1:0]    oPCE,
    output logic [ADDRESS_WIDTH-1:0] oRs1AddrE,
    output logic [ADDRESS_WIDTH-1:0] oRs2AddrE,
    output logic [ADDRESS_WIDTH-1:0] oRdAddrE,
    output logic [DATA_WIDTH-1:0]    oRegData1E,
    output logic [DATA_WIDTH-1:0]    oRegData2E,
    output logic [DATA_WIDTH-1:0]    oImmE,
    output logic [CTRL_WIDTH-1:0]    oCtrlE,
    output logic                     oStallFD,
    output logic [31:0]              oBubbleCount
);

    logic                     r_valid_e;
    logic [DATA_WIDTH-1:0]    r_pc_e;
    logic [ADDRESS_WIDTH-1:0] r_rs1_e;
    logic [ADDRESS_WIDTH-1:0] r_rs2_e;
    logic [ADDRESS_WIDTH-1:0] r_rd_e;
    logic [DATA_WIDTH-1:0]    r_data1_e;
    logic [DATA_WIDTH-1:0]    r_data2_e;
    logic [DATA_WIDTH-1:0]    r_imm_e;
    logic [CTRL_WIDTH-1:0]    r_ctrl_e;

    logic                     w_hazard;
    logic                     w_bubble;
    logic [DATA_WIDTH-1:0]    w_data1;
    logic [DATA_WIDTH-1:0]    w_data2;

    // Load in E whose destination feeds the instruction waiting in D.
    always_comb begin
        w_hazard = r_valid_e & r_ctrl_e[1] & (r_rd_e != '0) & iValidD &
                   ((r_rd_e == iRs1AddrD) | (r_rd_e == iRs2AddrD));
    end

    always_comb begin
        w_data1 = iRegData1D;
        if (iRs1AddrD == '0)
            w_data1 = '0;
        else if (iWbWriteEn && (iWbAddr == iRs1AddrD))
            w_data1 = iWbData;
    end

    always_comb begin
        w_data2 = iRegData2D;
        if (iRs2AddrD == '0)
            w_data2 = '0;
        else if (iWbWriteEn && (iWbAddr == iRs2AddrD))
            w_data2 = iWbData;
    end

    assign w_bubble = iFlush | (~iStallE & w_hazard);
    assign oStallFD = (w_hazard | iStallE) & ~iFlush;

    always_ff @(posedge iClk) begin
        if (!iRstN || w_bubble) begin
            r_valid_e <= 1'b0;
            r_pc_e    <= '0;
            r_rs1_e   <= '0;
            r_rs2_e   <= '0;
            r_rd_e    <= '0;
            r_data1_e <= '0;
            r_data2_e <= '0;
            r_imm_e   <= '0;
            r_ctrl_e  <= '0;
        end else if (!iStallE) begin
            r_valid_e <= iValidD;
            r_pc_e    <= iPCD;
            r_rs1_e   <= iRs1AddrD;
            r_rs2_e   <= iRs2AddrD;
            r_rd_e    <= iRdAddrD;
            r_data1_e <= w_data1;
            r_data2_e <= w_data2;
            r_imm_e   <= iImmD;
            r_ctrl_e  <= iValidD ? iCtrlD : '0;
        end
    end

`ifdef PIPE_DE_BUBBLE_CNT_EN
    logic [31:0] r_bubble_count;

    // Only bubbles that displace a real instruction are counted; saturates.
    always_ff @(posedge iClk) begin
        if (!iRstN)
            r_bubble_count <= '0;
        else if (w_bubble && iValidD && (r_bubble_count != 32'hFFFF_FFFF))
            r_bubble_count <= r_bubble_count + 32'd1;
    end

    assign oBubbleCount = r_bubble_count;
`else
    assign oBubbleCount = '0;
`endif

    assign oValidE    = r_valid_e;
    assign oPCE       = r_pc_e;
    assign oRs1AddrE  = r_rs1_e;
    assign oRs2AddrE  = r_rs2_e;
    assign oRdAddrE   = r_rd_e;
    assign oRegData1E = r_data1_e;
    assign oRegData2E = r_data2_e;
    assign oImmE      = r_imm_e;
    assign oCtrlE     = r_ctrl_e;

endmodule

// File: tb/tb_pipeline_reg_de.sv
// tb/tb_pipeline_reg_de.sv - directed self-checking bench for pipeline_reg_de
module tb_pipeline_reg_de;

    logic        iClk = 1'b0;
    logic        iRstN;
    logic        iValidD;
    logic [31:0] iPCD;
    logic [4:0]  iRs1AddrD, iRs2AddrD, iRdAddrD;
    logic [31:0] iRegData1D, iRegData2D, iImmD;
    logic [15:0] iCtrlD;
    logic        iWbWriteEn;
    logic [4:0]  iWbAddr;
    logic [31:0] iWbData;
    logic        iStallE, iFlush;
    logic        oValidE;
    logic [31:0] oPCE;
    logic [4:0]  oRs1AddrE, oRs2AddrE, oRdAddrE;
    logic [31:0] oRegData1E, oRegData2E, oImmE;
    logic [15:0] oCtrlE;
    logic        oStallFD;
    logic [31:0] oBubbleCount;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef PIPE_DE_BUBBLE_CNT_EN
    localparam logic [31:0] CNT_ONE = 32'd1;
    localparam logic [31:0] CNT_TWO = 32'd2;
`else
    localparam logic [31:0] CNT_ONE = 32'd0;
    localparam logic [31:0] CNT_TWO = 32'd0;
`endif

    pipeline_reg_de dut (
        .iClk(iClk), .iRstN(iRstN), .iValidD(iValidD), .iPCD(iPCD),
        .iRs1AddrD(iRs1AddrD), .iRs2AddrD(iRs2AddrD), .iRdAddrD(iRdAddrD),
        .iRegData1D(iRegData1D), .iRegData2D(iRegData2D), .iImmD(iImmD),
        .iCtrlD(iCtrlD), .iWbWriteEn(iWbWriteEn), .iWbAddr(iWbAddr),
        .iWbData(iWbData), .iStallE(iStallE), .iFlush(iFlush),
        .oValidE(oValidE), .oPCE(oPCE), .oRs1AddrE(oRs1AddrE),
        .oRs2AddrE(oRs2AddrE), .oRdAddrE(oRdAddrE), .oRegData1E(oRegData1E),
        .oRegData2E(oRegData2E), .oImmE(oImmE), .oCtrlE(oCtrlE),
        .oStallFD(oStallFD), .oBubbleCount(oBubbleCount)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    initial begin
        iRstN = 1'b0; iValidD = 1'b1; iPCD = 32'h44; iRs1AddrD = 5'd1; iRs2AddrD = 5'd2;
        iRdAddrD = 5'd3; iRegData1D = 32'h77; iRegData2D = 32'h88; iImmD = 32'h5;
        iCtrlD = 16'h3; iWbWriteEn = 1'b0; iWbAddr = 5'd0; iWbData = 32'h0;
        iStallE = 1'b1; iFlush = 1'b1;
        step();
        step();
        iStallE = 1'b0; iFlush = 1'b0; iValidD = 1'b0;
        #1;
        chk("reset_valid", {31'd0, oValidE}, 32'd0);
        chk("reset_pc", oPCE, 32'd0);
        chk("reset_data1", oRegData1E, 32'd0);
        chk("reset_ctrl", {16'd0, oCtrlE}, 32'd0);
        chk("reset_count", oBubbleCount, 32'd0);
        chk("reset_stallfd", {31'd0, oStallFD}, 32'd0);

        // Normal load
        iRstN = 1'b1; iValidD = 1'b1; iPCD = 32'h100; iRs1AddrD = 5'd3; iRs2AddrD = 5'd4;
        iRdAddrD = 5'd9; iRegData1D = 32'h11; iRegData2D = 32'h22; iImmD = 32'hFFFF_FFF0;
        iCtrlD = 16'h0001;
        step();
        chk("norm_data1", oRegData1E, 32'h11);
        chk("norm_data2", oRegData2E, 32'h22);
        chk("norm_valid", {31'd0, oValidE}, 32'd1);
        chk("norm_pc", oPCE, 32'h100);
        chk("norm_rs1", {27'd0, oRs1AddrE}, 32'd3);
        chk("norm_rd", {27'd0, oRdAddrE}, 32'd9);
        chk("norm_imm", oImmE, 32'hFFFF_FFF0);
        chk("norm_ctrl", {16'd0, oCtrlE}, 32'h1);

        // Writeback bypass on both sources
        iRs1AddrD = 5'd5; iRs2AddrD = 5'd5; iRegData1D = 32'hAAAA; iRegData2D = 32'hAAAA;
        iWbWriteEn = 1'b1; iWbAddr = 5'd5; iWbData = 32'h1234;
        step();
        chk("byp_data1", oRegData1E, 32'h1234);
        chk("byp_data2", oRegData2E, 32'h1234);

        // Index 0 never bypassed and reads as zero
        iRs1AddrD = 5'd0; iRs2AddrD = 5'd0; iWbAddr = 5'd0;
        step();
        chk("zero_data1", oRegData1E, 32'd0);
        chk("zero_data2", oRegData2E, 32'd0);

        // Invalid D slot clears control
        iWbWriteEn = 1'b0; iValidD = 1'b0; iCtrlD = 16'h0003; iRs1AddrD = 5'd1;
        step();
        chk("inv_valid", {31'd0, oValidE}, 32'd0);
        chk("inv_ctrl", {16'd0, oCtrlE}, 32'd0);

        // Load-use hazard
        iValidD = 1'b1; iCtrlD = 16'h0003; iRdAddrD = 5'd7; iRs1AddrD = 5'd1; iRs2AddrD = 5'd2;
        iPCD = 32'h180;
        step();
        iRs1AddrD = 5'd8; iRs2AddrD = 5'd7; iRdAddrD = 5'd10; iCtrlD = 16'h0001; iPCD = 32'h200;
        #1;
        chk("lu_stallfd", {31'd0, oStallFD}, 32'd1);
        step();
        chk("lu_bubble_valid", {31'd0, oValidE}, 32'd0);
        chk("lu_bubble_ctrl", {16'd0, oCtrlE}, 32'd0);
        chk("lu_stall_clear", {31'd0, oStallFD}, 32'd0);
        step();
        chk("lu_load_valid", {31'd0, oValidE}, 32'd1);
        chk("lu_load_pc", oPCE, 32'h200);
        chk("lu_load_rd", {27'd0, oRdAddrE}, 32'd10);
        chk("lu_count", oBubbleCount, CNT_ONE);

        // Flush beats stall
        iFlush = 1'b1; iStallE = 1'b1;
        #1;
        chk("fl_stallfd", {31'd0, oStallFD}, 32'd0);
        step();
        chk("fl_valid", {31'd0, oValidE}, 32'd0);
        chk("fl_ctrl", {16'd0, oCtrlE}, 32'd0);
        chk("fl_count", oBubbleCount, CNT_TWO);
        iFlush = 1'b0; iStallE = 1'b0;

        // Stall hold for 3 cycles, then reset mid-stall
        iPCD = 32'h300; iRdAddrD = 5'd11; iRs1AddrD = 5'd3; iRs2AddrD = 5'd4;
        iRegData1D = 32'h55; iRegData2D = 32'h66; iCtrlD = 16'h0001;
        step();
        iStallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            iPCD = 32'h400 + 32'(i); iRegData1D = 32'h99 + 32'(i); iRdAddrD = 5'd12 + 5'(i);
            step();
            chk("st_pc", oPCE, 32'h300);
            chk("st_data1", oRegData1E, 32'h55);
            chk("st_rd", {27'd0, oRdAddrE}, 32'd11);
            chk("st_valid", {31'd0, oValidE}, 32'd1);
            chk("st_stallfd", {31'd0, oStallFD}, 32'd1);
        end
        iRstN = 1'b0;
        step();
        chk("rst_valid", {31'd0, oValidE}, 32'd0);
        chk("rst_pc", oPCE, 32'd0);
        chk("rst_data1", oRegData1E, 32'd0);
        chk("rst_data2", oRegData2E, 32'd0);
        chk("rst_rd", {27'd0, oRdAddrE}, 32'd0);
        chk("rst_imm", oImmE, 32'd0);
        chk("rst_count", oBubbleCount, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
